can_frame_tracker: RTL and testbench

- Parametrised successor to the CAN Rx frame-length stage; sits after the bit sampler (sof/dvalid/din) and before the field deserialiser.
- Tracks the unstuffed bit position of each CAN 2.0A/2.0B frame, decodes RTR/SRR, IDE and DLC, and computes the exact frame length.
- Drives sample_en for the frame's duration, pulses frame_done on normal completion and frame_abort on error, overload or (optionally) bit timeout.

---
 rtl/can_frame_tracker.sv | 208 ++++++++++++++++++++
 tb/tb_can_frame_tracker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_frame_tracker.sv
// can_frame_tracker
// Follows the unstuffed bit position of a CAN 2.0A/2.0B frame from SOF to the
// last EOF bit. Decodes RTR/SRR, IDE and DLC as they pass and computes the
// exact frame length so the field deserialiser knows when the frame ends.
//
// Build option: define FRAME_TIMEOUT_EN to add a watchdog that aborts a frame
// after TIMEOUT_BITS nominal bit times without a dvalid strobe.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   sof                SOF detected (qualified by dvalid)
//   error, overload    abort requests, honoured only while a frame is active
//   din, dvalid        destuffed bit and its one-cycle valid strobe
//   bit_index          index of the next bit to be sampled (SOF = 0)
//   frame_length_bits  total frame bits SOF..EOF, stuff bits excluded
//   length_valid       frame_length_bits is final
//   ide, rtr, dlc      latched control fields (dlc is raw, MSB first)
//   data_bytes         payload bytes: 0 for remote frames, else min(dlc, MAX)
//   sample_en          high while a frame is active
//   frame_done         one-cycle pulse after the last EOF bit
//   frame_abort        one-cycle pulse when a frame is abandoned
module can_frame_tracker #(
  parameter int unsigned clk_speed_MHz      = 100,
  parameter int unsigned can_bit_rate_Kbits = 1000,
  parameter int unsigned CNT_W              = 8,
  parameter int unsigned MAX_DATA_BYTES     = 8,
  parameter int unsigned TIMEOUT_BITS       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             error,
  input  logic             overload,
  input  logic             din,
  input  logic             dvalid,
  output logic [CNT_W-1:0] bit_index,
  output logic [CNT_W-1:0] frame_length_bits,
  output logic             length_valid,
  output logic             ide,
  output logic             rtr,
  output logic [3:0]       dlc,
  output logic [3:0]       data_bytes,
  output logic             sample_en,
  output logic             frame_done,
  output logic             frame_abort
);

  // Elaboration-time sanity checks on the configuration.
  if (CNT_W < 8) begin : g_cnt_w_chk
    $error("can_frame_tracker: CNT_W must be at least 8");
  end
  if ((clk_speed_MHz * 1000 < can_bit_rate_Kbits) || (TIMEOUT_BITS == 0)) begin : g_rate_chk
    $error("can_frame_tracker: clock slower than bit rate or zero TIMEOUT_BITS");
  end

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StIdeChk,
    StStdCtrl,
    StExtId,
    StExtCtrl,
    StTail
  } state_e;

  localparam logic [CNT_W-1:0] IdxMax = {CNT_W{1'b1}};

  function automatic logic [3:0] payload_bytes(input logic is_remote, input logic [3:0] code);
    if (is_remote) return 4'd0;
    if ({28'd0, code} > MAX_DATA_BYTES) return 4'(MAX_DATA_BYTES);
    return code;
  endfunction

  function automatic logic [CNT_W-1:0] frame_len(input logic ext, input logic [3:0] bytes);
    return (ext ? CNT_W'(64) : CNT_W'(44)) + CNT_W'({bytes, 3'b000});
  endfunction

  state_e           state_q;
  logic             rtr_ssr_q;
  logic             active;
  logic [CNT_W-1:0] idx_next;
  logic [3:0]       dlc_shift;
  logic [3:0]       new_bytes;
  logic             timeout;

  assign active    = (state_q != StIdle);
  // Saturate rather than wrap so a runaway frame never aliases low indices.
  assign idx_next  = (bit_index == IdxMax) ? bit_index : bit_index + CNT_W'(1);
  assign dlc_shift = {dlc[2:0], din};
  // rtr is already latched by the time the last DLC bit arrives in both formats.
  assign new_bytes = payload_bytes(rtr, dlc_shift);

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TimeoutCycles =
      TIMEOUT_BITS * (clk_speed_MHz * 1000 / can_bit_rate_Kbits);
  localparam int unsigned WdW = $clog2(TimeoutCycles + 1);

  logic [WdW-1:0] wd_q;

  // Counts edges since the last dvalid; fires on the edge that reaches the limit.
  always_ff @(posedge clk) begin
    if (rst || !active || dvalid) begin
      wd_q <= '0;
    end else if (!timeout) begin
      wd_q <= wd_q + WdW'(1);
    end
  end

  assign timeout = active && !dvalid && (wd_q == WdW'(TimeoutCycles - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StIdle;
      rtr_ssr_q         <= 1'b0;
      bit_index         <= '0;
      frame_length_bits <= '0;
      length_valid      <= 1'b0;
      ide               <= 1'b0;
      rtr               <= 1'b0;
      dlc               <= '0;
      data_bytes        <= '0;
      sample_en         <= 1'b0;
      frame_done        <= 1'b0;
      frame_abort       <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      // Abort takes priority over any bit sampled in the same cycle.
      if (active && (error || overload || timeout)) begin
        state_q      <= StIdle;
        sample_en    <= 1'b0;
        frame_abort  <= 1'b1;
        length_valid <= 1'b0;
        bit_index    <= '0;
      end else if (dvalid) begin
        if (active) bit_index <= idx_next;
        unique case (state_q)
          StIdle: begin
            if (sof && !din) begin
              state_q      <= StArb;
              bit_index    <= CNT_W'(1);
              sample_en    <= 1'b1;
              ide          <= 1'b0;
              rtr          <= 1'b0;
              dlc          <= '0;
              data_bytes   <= '0;
              length_valid <= 1'b0;
            end
          end
          StArb: begin
            if (bit_index == CNT_W'(12)) begin
              rtr_ssr_q <= din;
              state_q   <= StIdeChk;
            end
          end
          StIdeChk: begin
            ide <= din;
            if (din) begin
              state_q <= StExtId;
            end else begin
              rtr     <= rtr_ssr_q;
              state_q <= StStdCtrl;
            end
          end
          StStdCtrl: begin
            // Bit 14 is r0; DLC occupies 15..18.
            if (bit_index >= CNT_W'(15)) dlc <= dlc_shift;
            if (bit_index == CNT_W'(18)) begin
              state_q           <= StTail;
              data_bytes        <= new_bytes;
              frame_length_bits <= frame_len(1'b0, new_bytes);
              length_valid      <= 1'b1;
            end
          end
          StExtId: begin
            if (bit_index == CNT_W'(32)) begin
              rtr     <= din;
              state_q <= StExtCtrl;
            end
          end
          StExtCtrl: begin
            // Bits 33-34 are r1/r0; DLC occupies 35..38.
            if (bit_index >= CNT_W'(35)) dlc <= dlc_shift;
            if (bit_index == CNT_W'(38)) begin
              state_q           <= StTail;
              data_bytes        <= new_bytes;
              frame_length_bits <= frame_len(1'b1, new_bytes);
              length_valid      <= 1'b1;
            end
          end
          StTail: begin
            if (bit_index == frame_length_bits - CNT_W'(1)) begin
              state_q    <= StIdle;
              sample_en  <= 1'b0;
              frame_done <= 1'b1;
              bit_index  <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_frame_tracker.sv
`timescale 1ns/1ps
module tb_can_frame_tracker;

  localparam int unsigned CNT_W       = 8;
  localparam int unsigned ClkMhz      = 100;
  localparam int unsigned BitKbps     = 1000;
  localparam int unsigned MaxBytes    = 8;
  localparam int unsigned TimeoutBits = 4;

  logic             clk = 1'b0;
  logic             rst, sof, error, overload, din, dvalid;
  logic [CNT_W-1:0] bit_index, frame_length_bits;
  logic             length_valid, ide, rtr, sample_en, frame_done, frame_abort;
  logic [3:0]       dlc, data_bytes;

  can_frame_tracker #(
    .clk_speed_MHz     (ClkMhz),
    .can_bit_rate_Kbits(BitKbps),
    .CNT_W             (CNT_W),
    .MAX_DATA_BYTES    (MaxBytes),
    .TIMEOUT_BITS      (TimeoutBits)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .sof              (sof),
    .error            (error),
    .overload         (overload),
    .din              (din),
    .dvalid           (dvalid),
    .bit_index        (bit_index),
    .frame_length_bits(frame_length_bits),
    .length_valid     (length_valid),
    .ide              (ide),
    .rtr              (rtr),
    .dlc              (dlc),
    .data_bytes       (data_bytes),
    .sample_en        (sample_en),
    .frame_done       (frame_done),
    .frame_abort      (frame_abort)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference frame: the bit sequence plus its decoded fields.
  logic frame_bits[$];
  int   m_ide, m_rtr, m_dlc, m_bytes, m_len;

  typedef struct {
    logic       ide;
    logic       rtr;
    logic [3:0] dlc;
    int         exp_len;
    int         exp_bytes;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one dvalid strobe; returns 1ns after the sampling edge.
  task automatic send_bit(input logic b, input logic s, input logic e, input logic o);
    din = b; sof = s; error = e; overload = o; dvalid = 1'b1;
    @(posedge clk); #1;
    dvalid = 1'b0; sof = 1'b0; error = 1'b0; overload = 1'b0;
    din = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      chk("no_pulse_idle", {30'd0, frame_done, frame_abort}, 0);
    end
  endtask

  // Builds the unstuffed bit sequence of a frame and its expected fields.
  task automatic build_frame(input logic f_ide, input logic f_rtr, input logic [3:0] f_dlc);
    m_ide   = int'(f_ide);
    m_rtr   = int'(f_rtr);
    m_dlc   = int'(f_dlc);
    m_bytes = m_rtr ? 0 : ((m_dlc > MaxBytes) ? MaxBytes : m_dlc);
    m_len   = (m_ide ? 64 : 44) + 8 * m_bytes;
    frame_bits.delete();
    frame_bits.push_back(1'b0);                                   // SOF
    for (int j = 0; j < 11; j++) frame_bits.push_back(1'($urandom_range(0, 1)));
    if (!f_ide) begin
      frame_bits.push_back(f_rtr);                                // bit 12 RTR
      frame_bits.push_back(1'b0);                                 // IDE
      frame_bits.push_back(1'b0);                                 // r0
    end else begin
      frame_bits.push_back(1'($urandom_range(0, 1)));             // SRR
      frame_bits.push_back(1'b1);                                 // IDE
      for (int j = 0; j < 18; j++) frame_bits.push_back(1'($urandom_range(0, 1)));
      frame_bits.push_back(f_rtr);                                // bit 32 RTR
      frame_bits.push_back(1'($urandom_range(0, 1)));             // r1
      frame_bits.push_back(1'($urandom_range(0, 1)));             // r0
    end
    for (int j = 3; j >= 0; j--) frame_bits.push_back(f_dlc[j]);
    while (frame_bits.size() < m_len) frame_bits.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic check_bit(input int i);
    int  dlc_end;
    bit  fin;
    dlc_end = m_ide ? 38 : 18;
    fin     = (i == m_len - 1);
    chk("bit_index", 32'(bit_index), fin ? 0 : i + 1);
    chk("sample_en", 32'(sample_en), fin ? 0 : 1);
    chk("frame_done", 32'(frame_done), fin ? 1 : 0);
    chk("frame_abort", 32'(frame_abort), 0);
    chk("length_valid", 32'(length_valid), (i >= dlc_end) ? 1 : 0);
    if (i >= dlc_end) begin
      chk("frame_length_bits", 32'(frame_length_bits), m_len);
      chk("data_bytes", 32'(data_bytes), m_bytes);
      chk("dlc", 32'(dlc), m_dlc);
    end
    if (i >= 13) chk("ide", 32'(ide), m_ide);
    if (i >= (m_ide ? 32 : 13)) chk("rtr", 32'(rtr), m_rtr);
  endtask

  // Plays bits 0..upto-1 with random gaps and stray sof, checking every bit.
  task automatic play_frame(input int upto);
    for (int i = 0; i < upto; i++) begin
      logic s;
      if (i > 0) idle($urandom_range(0, 3));
      s = (i == 0) ? 1'b1 : 1'($urandom_range(0, 7) == 0);
      send_bit(frame_bits[i], s, 1'b0, 1'b0);
      check_bit(i);
    end
  endtask

  task automatic check_aborted(input string tag);
    chk({tag, "_abort"}, 32'(frame_abort), 1);
    chk({tag, "_done"}, 32'(frame_done), 0);
    chk({tag, "_sample_en"}, 32'(sample_en), 0);
    chk({tag, "_length_valid"}, 32'(length_valid), 0);
  endtask

  initial begin
    int  k;
    bit  seen;
    logic e;

    vecs[0] = '{1'b0, 1'b0, 4'd8,  108, 8};
    vecs[1] = '{1'b0, 1'b1, 4'd4,  44,  0};
    vecs[2] = '{1'b1, 1'b0, 4'd2,  80,  2};
    vecs[3] = '{1'b0, 1'b0, 4'd15, 108, 8};
    vecs[4] = '{1'b1, 1'b0, 4'd15, 128, 8};
    vecs[5] = '{1'b1, 1'b1, 4'd3,  64,  0};
    vecs[6] = '{1'b0, 1'b0, 4'd0,  44,  0};
    vecs[7] = '{1'b0, 1'b0, 4'd1,  52,  1};

    rst = 1'b1; sof = 1'b0; error = 1'b0; overload = 1'b0; din = 1'b0; dvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {8'd0, bit_index, frame_length_bits, 4'd0, length_valid, ide, rtr, sample_en},
        0);
    chk("reset_fields", {24'd0, dlc, data_bytes}, 0);
    chk("reset_pulses", {30'd0, frame_done, frame_abort}, 0);
    rst = 1'b0;

    // Idle: recessive SOF, bare dvalid and abort flags must not start anything.
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sof_recessive_ignored", {23'd0, bit_index, sample_en}, 0);
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    chk("dvalid_no_sof_ignored", 32'(sample_en), 0);
    error = 1'b1; overload = 1'b1;
    @(posedge clk); #1;
    error = 1'b0; overload = 1'b0;
    chk("idle_error_no_pulse", {30'd0, frame_abort, sample_en}, 0);

    // Directed frame table.
    for (int v = 0; v < 8; v++) begin
      build_frame(vecs[v].ide, vecs[v].rtr, vecs[v].dlc);
      play_frame(m_len);
      chk("tbl_length", 32'(frame_length_bits), vecs[v].exp_len);
      chk("tbl_data_bytes", 32'(data_bytes), vecs[v].exp_bytes);
      chk("tbl_dlc", 32'(dlc), int'(vecs[v].dlc));
      chk("tbl_ide_rtr", {30'd0, ide, rtr}, int'({vecs[v].ide, vecs[v].rtr}));
      idle(2);
    end

    // Error together with the dvalid of bit 20, then a clean restart.
    build_frame(1'b0, 1'b0, 4'd8);
    play_frame(20);
    send_bit(frame_bits[20], 1'b0, 1'b1, 1'b0);
    check_aborted("err_bit20");
    seen = 1'b0;
    for (int i = 21; i < 60; i++) begin
      send_bit(frame_bits[i], 1'b0, 1'b0, 1'b0);
      if (frame_done || sample_en) seen = 1'b1;
    end
    chk("err_bit20_stays_idle", 32'(seen), 0);
    build_frame(1'b0, 1'b0, 4'd8);
    play_frame(m_len);
    idle(1);

    // Overload on the final EOF bit: abort wins over completion.
    build_frame(1'b0, 1'b1, 4'd4);
    play_frame(m_len - 1);
    send_bit(frame_bits[m_len - 1], 1'b0, 1'b0, 1'b1);
    check_aborted("ovl_last_bit");
    idle(1);

    // Reset at bit 50 overrides a simultaneous dvalid/sof/error.
    build_frame(1'b0, 1'b0, 4'd8);
    play_frame(50);
    rst = 1'b1; dvalid = 1'b1; sof = 1'b1; din = 1'b0; error = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; dvalid = 1'b0; sof = 1'b0; error = 1'b0;
    chk("rst_mid_outputs",
        {8'd0, bit_index, frame_length_bits, 4'd0, length_valid, ide, rtr, sample_en},
        0);
    chk("rst_mid_fields", {22'd0, dlc, data_bytes, frame_done, frame_abort}, 0);

    // Stalled frame: dvalid stops after bit 29.
    build_frame(1'b0, 1'b0, 4'd8);
    play_frame(30);
    k = 0;
    seen = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    while (k < 1000 && !seen) begin
      @(posedge clk); #1;
      k++;
      if (frame_abort) seen = 1'b1;
    end
    chk("timeout_fired", 32'(seen), 1);
    chk("timeout_cycles", 32'(k), int'(TimeoutBits * (ClkMhz * 1000 / BitKbps)));
    chk("timeout_sample_en", 32'(sample_en), 0);
    chk("timeout_done", 32'(frame_done), 0);
`else
    while (k < 600) begin
      @(posedge clk); #1;
      k++;
      if (frame_abort) seen = 1'b1;
    end
    chk("stall_no_abort", 32'(seen), 0);
    chk("stall_still_active", {23'd0, bit_index, sample_en}, (30 << 1) | 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`endif
    idle(1);

    // Randomized frames against the reference model, some aborted mid-frame.
    for (int r = 0; r < 30; r++) begin
      build_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(1, m_len - 1);
        play_frame(k);
        e = 1'($urandom_range(0, 1));
        send_bit(frame_bits[k], 1'b0, e, !e);
        check_aborted("rand_abort");
      end else begin
        play_frame(m_len);
      end
      idle($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
